// File: rtl/mode_counter.sv
// Up/down counter with programmable inclusive limit, wrap/saturate boundaries, load, tc strobe and sticky ovf.
// Define COUNTER_PRESCALE_EN to divide en_i through an internal prescaler.
module mode_counter #(
  parameter int unsigned              COUNTER_WIDTH  = 8,
  parameter logic [COUNTER_WIDTH-1:0] RESET_VAL      = '0,
  parameter int unsigned              PRESCALE_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      clr_i,
  input  logic                      load_i,
  input  logic [COUNTER_WIDTH-1:0]  load_val_i,
  input  logic                      en_i,
  input  logic                      dir_i,
  input  logic                      sat_i,
  input  logic [COUNTER_WIDTH-1:0]  max_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  output logic [COUNTER_WIDTH-1:0]  count_o,
  output logic                      tc_o,
  output logic                      ovf_o
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  logic [COUNTER_WIDTH-1:0] count_q, count_d;
  logic                     ovf_q, ovf_d;
  logic                     presc_hit;
  logic                     step;
  logic                     at_bound;
  logic                     tc;

`ifdef COUNTER_PRESCALE_EN
  localparam logic [PRESCALE_WIDTH-1:0] PRESC_ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;

  assign presc_hit = (presc_q == prescale_i);

  always_comb begin
    presc_d = presc_q;
    if (clr_i || load_i) begin
      presc_d = '0;
    end else if (en_i) begin
      presc_d = presc_hit ? '0 : presc_q + PRESC_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale_i;
  assign presc_hit       = 1'b1;
`endif

  // Up treats any count at or above the limit as the boundary; down only ever stops at zero.
  assign at_bound = dir_i ? (count_q >= max_i) : (count_q == '0);
  assign step     = en_i && !clr_i && !load_i && presc_hit;
  assign tc       = step && at_bound;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr_i) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (step) begin
      ovf_d = ovf_q | tc;
      if (dir_i) begin
        if (at_bound) count_d = sat_i ? max_i : '0;
        else          count_d = count_q + CNT_ONE;
      end else begin
        if (at_bound) count_d = sat_i ? '0 : max_i;
        else          count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= RESET_VAL;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign tc_o    = tc && rst_ni;

endmodule

// File: tb/tb_mode_counter.sv
// Self-checking bench for mode_counter (RESET_VAL=5): table-driven steps through a scoreboard queue.
module tb_mode_counter;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       clr_i, load_i, en_i, dir_i, sat_i;
  logic [7:0] load_val_i, max_i, count_o;
  logic [3:0] prescale_i;
  logic       tc_o, ovf_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       clr;
    logic       load;
    logic [7:0] lv;
    logic       en;
    logic       dir;
    logic       sat;
    logic [7:0] mx;
    logic [7:0] cnt;
    logic       tc;
    logic       ovf;
  } step_t;

  step_t sb[$];

  mode_counter #(
    .COUNTER_WIDTH (8),
    .RESET_VAL     (8'd5),
    .PRESCALE_WIDTH(4)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (clr_i),
    .load_i    (load_i),
    .load_val_i(load_val_i),
    .en_i      (en_i),
    .dir_i     (dir_i),
    .sat_i     (sat_i),
    .max_i     (max_i),
    .prescale_i(prescale_i),
    .count_o   (count_o),
    .tc_o      (tc_o),
    .ovf_o     (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic step_t mk(logic c, logic l, logic [7:0] lv, logic e, logic d, logic s,
                               logic [7:0] mx, logic [7:0] cnt, logic tc, logic ovf);
    step_t r;
    r = '{clr: c, load: l, lv: lv, en: e, dir: d, sat: s, mx: mx, cnt: cnt, tc: tc, ovf: ovf};
    return r;
  endfunction

  task automatic apply(input step_t s);
    clr_i      = s.clr;
    load_i     = s.load;
    load_val_i = s.lv;
    en_i       = s.en;
    dir_i      = s.dir;
    sat_i      = s.sat;
    max_i      = s.mx;
  endtask

  task automatic test_reset();
    step_t t[$];
    step_t e;
    rst_ni = 1'b0; clr_i = 0; load_i = 0; load_val_i = 0; prescale_i = 0;
    en_i = 1; dir_i = 1; sat_i = 0; max_i = 8'd3;
    #12;
    checks++; if (count_o !== 8'd5) begin errors++; $display("FAIL reset.count got %0d want 5", count_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset.ovf got %b want 0", ovf_o); end
    checks++; if (tc_o !== 1'b0) begin errors++; $display("FAIL reset.tc_in_reset got %b want 0", tc_o); end
    @(negedge clk_i); rst_ni = 1'b1; en_i = 0;
    @(posedge clk_i); #1;
    checks++; if (count_o !== 8'd5) begin errors++; $display("FAIL reset.count_after got %0d want 5", count_o); end
    checks++; if (tc_o !== 1'b0) begin errors++; $display("FAIL reset.tc_after got %b want 0", tc_o); end
    t.push_back(mk(0, 1, 8'd6, 0, 1, 0, 8'd20, 8'd6, 0, 0));
    t.push_back(mk(0, 0, 8'd0, 1, 1, 0, 8'd20, 8'd7, 0, 0));
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]); #1;
      checks++; if (tc_o !== sb[0].tc) begin errors++; $display("FAIL reset_pre.tc[%0d] got %b want %b", i, tc_o, sb[0].tc); end
      @(posedge clk_i); #1; e = sb.pop_front();
      checks++; if (count_o !== e.cnt) begin errors++; $display("FAIL reset_pre.count[%0d] got %0d want %0d", i, count_o, e.cnt); end
    end
    #2 rst_ni = 1'b0; #1;
    checks++; if (count_o !== 8'd5) begin errors++; $display("FAIL reset.async_count got %0d want 5", count_o); end
    @(negedge clk_i); rst_ni = 1'b1; en_i = 0;
    @(posedge clk_i); #1;
    checks++; if (count_o !== 8'd5) begin errors++; $display("FAIL reset.no_pending_step got %0d want 5", count_o); end
  endtask

  task automatic test_up_wrap();
    step_t t[$];
    step_t e;
    t.push_back(mk(1, 0, 0, 0, 1, 0, 8'd3, 8'd0, 0, 0));
    t.push_back(mk(0, 0, 0, 1, 1, 0, 8'd3, 8'd1, 0, 0));
    t.push_back(mk(0, 0, 0, 1, 1, 0, 8'd3, 8'd2, 0, 0));
    t.push_back(mk(0, 0, 0, 1, 1, 0, 8'd3, 8'd3, 0, 0));
    t.push_back(mk(0, 0, 0, 1, 1, 0, 8'd3, 8'd0, 1, 1));
    t.push_back(mk(0, 0, 0, 1, 1, 0, 8'd3, 8'd1, 0, 1));
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]); #1;
      checks++; if (tc_o !== sb[0].tc) begin errors++; $display("FAIL up_wrap.tc[%0d] got %b want %b", i, tc_o, sb[0].tc); end
      @(posedge clk_i); #1; e = sb.pop_front();
      checks++; if (count_o !== e.cnt) begin errors++; $display("FAIL up_wrap.count[%0d] got %0d want %0d", i, count_o, e.cnt); end
      checks++; if (ovf_o !== e.ovf) begin errors++; $display("FAIL up_wrap.ovf[%0d] got %b want %b", i, ovf_o, e.ovf); end
    end
  endtask

  task automatic test_down_sat();
    step_t t[$];
    step_t e;
    t.push_back(mk(0, 1, 8'd2, 0, 0, 1, 8'd3, 8'd2, 0, 1));
    t.push_back(mk(0, 0, 0, 1, 0, 1, 8'd3, 8'd1, 0, 1));
    t.push_back(mk(0, 0, 0, 1, 0, 1, 8'd3, 8'd0, 0, 1));
    t.push_back(mk(0, 0, 0, 1, 0, 1, 8'd3, 8'd0, 1, 1));
    t.push_back(mk(0, 0, 0, 1, 0, 1, 8'd3, 8'd0, 1, 1));
    t.push_back(mk(0, 0, 0, 0, 0, 1, 8'd3, 8'd0, 0, 1));
    t.push_back(mk(1, 0, 0, 0, 0, 1, 8'd3, 8'd0, 0, 0));
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]); #1;
      checks++; if (tc_o !== sb[0].tc) begin errors++; $display("FAIL down_sat.tc[%0d] got %b want %b", i, tc_o, sb[0].tc); end
      @(posedge clk_i); #1; e = sb.pop_front();
      checks++; if (count_o !== e.cnt) begin errors++; $display("FAIL down_sat.count[%0d] got %0d want %0d", i, count_o, e.cnt); end
      checks++; if (ovf_o !== e.ovf) begin errors++; $display("FAIL down_sat.ovf[%0d] got %b want %b", i, ovf_o, e.ovf); end
    end
  endtask

  task automatic test_priority();
    step_t t[$];
    step_t e;
    t.push_back(mk(0, 1, 8'd9,   0, 1, 0, 8'd10, 8'd9,   0, 0));
    t.push_back(mk(1, 1, 8'd50,  1, 1, 0, 8'd10, 8'd0,   0, 0));
    t.push_back(mk(0, 1, 8'd200, 1, 1, 0, 8'd10, 8'd200, 0, 0));
    t.push_back(mk(0, 1, 8'd200, 1, 1, 0, 8'd10, 8'd200, 0, 0));
    t.push_back(mk(0, 0, 0,      1, 1, 0, 8'd10, 8'd0,   1, 1));
    t.push_back(mk(0, 1, 8'd4,   1, 1, 0, 8'd10, 8'd4,   0, 1));
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]); #1;
      checks++; if (tc_o !== sb[0].tc) begin errors++; $display("FAIL priority.tc[%0d] got %b want %b", i, tc_o, sb[0].tc); end
      @(posedge clk_i); #1; e = sb.pop_front();
      checks++; if (count_o !== e.cnt) begin errors++; $display("FAIL priority.count[%0d] got %0d want %0d", i, count_o, e.cnt); end
      checks++; if (ovf_o !== e.ovf) begin errors++; $display("FAIL priority.ovf[%0d] got %b want %b", i, ovf_o, e.ovf); end
    end
  endtask

  task automatic test_boundaries();
    step_t t[$];
    step_t e;
    t.push_back(mk(1, 0, 0,    0, 0, 0, 8'd6, 8'd0, 0, 0));
    t.push_back(mk(0, 0, 0,    1, 0, 0, 8'd6, 8'd6, 1, 1));
    t.push_back(mk(0, 0, 0,    1, 1, 0, 8'd2, 8'd0, 1, 1));
    t.push_back(mk(0, 1, 8'd9, 0, 0, 0, 8'd2, 8'd9, 0, 1));
    t.push_back(mk(0, 0, 0,    1, 0, 0, 8'd2, 8'd8, 0, 1));
    t.push_back(mk(1, 0, 0,    0, 1, 0, 8'd0, 8'd0, 0, 0));
    t.push_back(mk(0, 0, 0,    1, 1, 0, 8'd0, 8'd0, 1, 1));
    t.push_back(mk(0, 0, 0,    1, 1, 0, 8'd0, 8'd0, 1, 1));
    t.push_back(mk(0, 1, 8'd3, 0, 1, 1, 8'd4, 8'd3, 0, 1));
    t.push_back(mk(0, 0, 0,    1, 1, 1, 8'd4, 8'd4, 0, 1));
    t.push_back(mk(0, 0, 0,    1, 1, 1, 8'd4, 8'd4, 1, 1));
    t.push_back(mk(0, 0, 0,    1, 1, 1, 8'd4, 8'd4, 1, 1));
    t.push_back(mk(0, 1, 8'd255, 0, 1, 0, 8'd255, 8'd255, 0, 1));
    t.push_back(mk(0, 0, 0,    1, 1, 0, 8'd255, 8'd0, 1, 1));
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]); #1;
      checks++; if (tc_o !== sb[0].tc) begin errors++; $display("FAIL boundary.tc[%0d] got %b want %b", i, tc_o, sb[0].tc); end
      @(posedge clk_i); #1; e = sb.pop_front();
      checks++; if (count_o !== e.cnt) begin errors++; $display("FAIL boundary.count[%0d] got %0d want %0d", i, count_o, e.cnt); end
      checks++; if (ovf_o !== e.ovf) begin errors++; $display("FAIL boundary.ovf[%0d] got %b want %b", i, ovf_o, e.ovf); end
    end
  endtask

`ifdef COUNTER_PRESCALE_EN
  task automatic test_prescale();
    step_t t[$];
    step_t e;
    prescale_i = 4'd2;
    t.push_back(mk(1, 0, 0,     0, 1, 0, 8'd100, 8'd0,  0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd0,  0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd0,  0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd1,  0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd1,  0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd1,  0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd2,  0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd2,  0, 0));
    t.push_back(mk(0, 0, 0,     0, 1, 0, 8'd100, 8'd2,  0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd2,  0, 0));
    t.push_back(mk(0, 0, 0,     0, 1, 0, 8'd100, 8'd2,  0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd3,  0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd3,  0, 0));
    t.push_back(mk(0, 1, 8'd10, 1, 1, 0, 8'd100, 8'd10, 0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd10, 0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd10, 0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd100, 8'd11, 0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd11,  8'd11, 0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd11,  8'd11, 0, 0));
    t.push_back(mk(0, 0, 0,     1, 1, 0, 8'd11,  8'd0,  1, 1));
    foreach (t[i]) begin
      apply(t[i]); sb.push_back(t[i]); #1;
      checks++; if (tc_o !== sb[0].tc) begin errors++; $display("FAIL prescale.tc[%0d] got %b want %b", i, tc_o, sb[0].tc); end
      @(posedge clk_i); #1; e = sb.pop_front();
      checks++; if (count_o !== e.cnt) begin errors++; $display("FAIL prescale.count[%0d] got %0d want %0d", i, count_o, e.cnt); end
      checks++; if (ovf_o !== e.ovf) begin errors++; $display("FAIL prescale.ovf[%0d] got %b want %b", i, ovf_o, e.ovf); end
    end
    prescale_i = 4'd0;
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_sat();
    test_priority();
    test_boundaries();
`ifdef COUNTER_PRESCALE_EN
    test_prescale();
`endif
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard.leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
